// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: controller states, S-box size and the byte type.
// Kept free of encrypt-specific items so the cracking block can import it as-is.
package arc4_pkg;
  localparam int SBOX_SIZE = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_LEN,
    ST_PRGA
  } arc4_state_e;
endpackage

// File: rtl/arc4_sbox.sv
// ARC4 S-box: 256x8 single-port RAM, write-enable, one-cycle synchronous read.
module arc4_sbox
  import arc4_pkg::*;
(
  input  logic  clk,
  input  byte_t addr,
  input  byte_t wrdata,
  input  logic  wren,
  output byte_t rddata
);
  byte_t mem [SBOX_SIZE];

  always_ff @(posedge clk) begin
    if (wren) mem[addr] <= wrdata;
    rddata <= mem[addr];
  end
endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor for length-prefixed messages, built around one single-port S-box.
// Optional ARC4_ENCRYPT_CYCLE_CNT_EN adds a saturating 16-bit busy-cycle counter port.
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
`ifdef ARC4_ENCRYPT_CYCLE_CNT_EN
  output logic [15:0]            cycles,
`endif
  output logic                   ct_wren
);
  arc4_state_e state, state_nx;
  logic [2:0]  ph, ph_nx;
  logic [8*KEY_BYTES-1:0] key_q;
  byte_t cnt, j, k, len, si, sj, ptb, kidx;
  byte_t s_addr, s_wdata, s_rd, key_byte, j_ksa, j_prga, i_nx;
  logic  s_we;

  arc4_sbox u_sbox (
    .clk    (clk),
    .addr   (s_addr),
    .wrdata (s_wdata),
    .wren   (s_we),
    .rddata (s_rd)
  );

  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++)
      if (kidx == b[7:0]) key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
  end

  assign j_ksa  = j + s_rd + key_byte;
  assign j_prga = j + s_rd;
  assign i_nx   = cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      ph    <= '0;
    end else begin
      state <= state_nx;
      ph    <= ph_nx;
    end
  end

  // Each KSA step is read i / read j / write i / write j; PRGA adds the key-stream lookup.
  always_comb begin
    state_nx  = state;
    ph_nx     = ph;
    s_addr    = '0;
    s_wdata   = '0;
    s_we      = 1'b0;
    rdy       = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_nx = ST_INIT;
          ph_nx    = '0;
        end
      end
      ST_INIT: begin
        s_addr  = cnt;
        s_wdata = cnt;
        s_we    = 1'b1;
        if (cnt == 8'hFF) state_nx = ST_KSA;
      end
      ST_KSA: begin
        case (ph)
          3'd0: begin s_addr = cnt; ph_nx = 3'd1; end
          3'd1: begin s_addr = j_ksa; ph_nx = 3'd2; end
          3'd2: begin s_addr = cnt; s_wdata = s_rd; s_we = 1'b1; ph_nx = 3'd3; end
          default: begin
            s_addr  = j;
            s_wdata = si;
            s_we    = 1'b1;
            ph_nx   = 3'd0;
            if (cnt == 8'hFF) state_nx = ST_LEN;
          end
        endcase
      end
      ST_LEN: begin
        if (ph == 3'd0) begin
          ph_nx = 3'd1;
        end else begin
          ct_wren   = 1'b1;
          ct_wrdata = pt_rddata;
          ph_nx     = 3'd0;
          state_nx  = (pt_rddata == 8'h00) ? ST_IDLE : ST_PRGA;
        end
      end
      ST_PRGA: begin
        pt_addr = k;
        case (ph)
          3'd0: begin s_addr = i_nx; ph_nx = 3'd1; end
          3'd1: begin s_addr = j_prga; ph_nx = 3'd2; end
          3'd2: begin s_addr = cnt; s_wdata = s_rd; s_we = 1'b1; ph_nx = 3'd3; end
          3'd3: begin s_addr = j; s_wdata = si; s_we = 1'b1; ph_nx = 3'd4; end
          3'd4: begin s_addr = si + sj; ph_nx = 3'd5; end
          default: begin
            ct_wren   = 1'b1;
            ct_addr   = k;
            ct_wrdata = ptb ^ s_rd;
            ph_nx     = 3'd0;
            if (k == len) state_nx = ST_IDLE;
          end
        endcase
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      cnt   <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      ptb   <= '0;
      kidx  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (en) begin
          key_q <= key;
          cnt   <= '0;
        end
        ST_INIT: begin
          cnt  <= i_nx;   // wraps to 0, which is KSA's first i
          j    <= '0;
          kidx <= '0;
        end
        ST_KSA: begin
          if (ph == 3'd1) begin
            si <= s_rd;
            j  <= j_ksa;
          end
          if (ph == 3'd3) begin
            cnt  <= i_nx;
            kidx <= (kidx == 8'(KEY_BYTES-1)) ? 8'd0 : kidx + 8'd1;
          end
        end
        ST_LEN: if (ph != 3'd0) begin
          len <= pt_rddata;
          cnt <= '0;
          j   <= '0;
          k   <= 8'd1;
        end
        ST_PRGA: begin
          case (ph)
            3'd0: cnt <= i_nx;
            3'd1: begin
              si  <= s_rd;
              j   <= j_prga;
              ptb <= pt_rddata;
            end
            3'd2: sj <= s_rd;
            3'd5: k  <= k + 8'd1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef ARC4_ENCRYPT_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cycles <= '0;
    else if (state == ST_IDLE && en)
      cycles <= '0;
    else if (state != ST_IDLE && cycles != 16'hFFFF)
      cycles <= cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt: software ARC4 model feeds a scoreboard of ct writes.
module tb_arc4_encrypt;
  import arc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [23:0] key = '0;
  logic        rdy, ct_wren;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;
`ifdef ARC4_ENCRYPT_CYCLE_CNT_EN
  logic [15:0] cycles;
`endif

  arc4_encrypt #(.KEY_BYTES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
`ifdef ARC4_ENCRYPT_CYCLE_CNT_EN
    .cycles    (cycles),
`endif
    .ct_wren   (ct_wren)
  );

  always #5 clk = ~clk;

  byte_t pt_mem [256];
  byte_t ct_mem [256];
  byte_t orig   [256];
  byte_t exp_q  [$];
  int checks = 0, failures = 0;
  int wr_cnt = 0, exp_addr = 0, max_pt = 0, last_addr = -1;

  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  always @(negedge clk) begin
    byte_t exp_b;
    if (!rst && !rdy && int'(pt_addr) > max_pt) max_pt = int'(pt_addr);
    if (!rst && ct_wren) begin
      checks++;
      assert (int'(ct_addr) === exp_addr) else begin
        failures++;
        $error("FAIL ct_addr observed=%0d expected=%0d", ct_addr, exp_addr);
      end
      exp_addr++;
      wr_cnt++;
      last_addr = int'(ct_addr);
      ct_mem[ct_addr] = ct_wrdata;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL extra_write addr=%0d observed=%0d expected=none", ct_addr, ct_wrdata);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        checks++;
        assert (ct_wrdata === exp_b) else begin
          failures++;
          $error("FAIL ct_data addr=%0d observed=%h expected=%h", ct_addr, ct_wrdata, exp_b);
        end
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference ARC4 over pt_mem; pushes the expected ct bytes, length byte first.
  task automatic model(input logic [23:0] kk);
    int s [256];
    int i, j, t, len;
    exp_q.delete();
    for (int m = 0; m < 256; m++) s[m] = m;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(kk[8*(2-(n%3)) +: 8])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(pt_mem[0]);
    exp_q.push_back(pt_mem[0]);
    i = 0; j = 0;
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_q.push_back(pt_mem[n] ^ 8'(s[(s[i] + s[j]) % 256]));
    end
  endtask

  task automatic start_run(input logic [23:0] kk);
    @(negedge clk);
    wr_cnt = 0; exp_addr = 0; max_pt = 0; last_addr = -1;
    key = kk;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    check("rdy_drop", int'(rdy), 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!rdy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, int'(rdy), 1);
  endtask

  task automatic load_mindstorms();
    string msg = "mindstorms";
    pt_mem[0] = 8'd10;
    for (int n = 0; n < 10; n++) pt_mem[n+1] = msg[n];
  endtask

  initial begin
    int n;
    for (int m = 0; m < 256; m++) pt_mem[m] = '0;
    // reset together with en: reset values, then no operation started
    en = 1'b1;
    @(negedge clk);
    check("rst_rdy", int'(rdy), 1);
    check("rst_wren", int'(ct_wren), 0);
    check("rst_pt_addr", int'(pt_addr), 0);
    check("rst_ct_addr", int'(ct_addr), 0);
    check("rst_ct_wrdata", int'(ct_wrdata), 0);
    rst = 1'b0;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en_idle", int'(rdy), 1);

    // mindstorms, key 0x000018
    load_mindstorms();
    model(24'h000018);
    start_run(24'h000018);
    wait_done("ms");
    check("ms_writes", wr_cnt, 11);
    check("ms_queue", exp_q.size(), 0);
    check("ms_len_byte", int'(ct_mem[0]), 8'h0A);
    check("ms_pt_max", int'(max_pt <= 10), 1);

    // round trip: ciphertext back in, original plaintext out
    for (int m = 0; m < 11; m++) begin
      orig[m]   = pt_mem[m];
      pt_mem[m] = ct_mem[m];
    end
    exp_q.delete();
    for (int m = 0; m < 11; m++) exp_q.push_back(orig[m]);
    start_run(24'h000018);
    wait_done("rt");
    check("rt_writes", wr_cnt, 11);
    check("rt_queue", exp_q.size(), 0);

    // empty message
    pt_mem[0] = 8'h00;
    model(24'h123456);
    start_run(24'h123456);
    wait_done("l0");
    check("l0_writes", wr_cnt, 1);
    check("l0_queue", exp_q.size(), 0);

    // maximum length, all-ones key
    pt_mem[0] = 8'hFF;
    for (int m = 1; m < 256; m++) pt_mem[m] = 8'($urandom_range(0, 255));
    model(24'hFFFFFF);
    start_run(24'hFFFFFF);
    wait_done("l255");
    check("l255_writes", wr_cnt, 256);
    check("l255_last_addr", last_addr, 255);
    check("l255_pt_max", max_pt, 255);
    check("l255_queue", exp_q.size(), 0);

    // reset during KSA, then a clean run
    load_mindstorms();
    exp_q.delete();
    start_run(24'h000018);
    repeat (400) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rdy", int'(rdy), 1);
    check("abort_wren", int'(ct_wren), 0);
    check("abort_writes", wr_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    model(24'h000018);
    start_run(24'h000018);
    wait_done("post_abort");
    check("post_abort_writes", wr_cnt, 11);
    check("post_abort_queue", exp_q.size(), 0);

    // en pulse while busy in PRGA is ignored
    model(24'h000018);
    start_run(24'h000018);
    n = 0;
    while (wr_cnt < 3 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("busy_reached_prga", int'(wr_cnt >= 3), 1);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done("busy");
    check("busy_writes", wr_cnt, 11);
    check("busy_queue", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("busy_not_queued", int'(rdy), 1);
    check("busy_no_extra", wr_cnt, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
